// File: rtl/nway_cache_tracker_table_if.sv
// Allocation / issue / retire / lookup bundle of the n-way cache tracker table.
// master: trace capture and cache request path; slave: the tracker table itself.
interface nway_cache_tracker_table_if #(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 17
);
  localparam int unsigned SLOT_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);

  // Allocation
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [ADDR_WIDTH-1:0]  alloc_addr;
  logic [INDEX_WIDTH-1:0] alloc_index;
  logic [SLOT_W-1:0]      alloc_slot;

  // Issue
  logic                   issue_valid;
  logic                   issue_ready;
  logic [SLOT_W-1:0]      issue_slot;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic [INDEX_WIDTH-1:0] issue_index;

  // Retire
  logic                   retire_valid;
  logic [SLOT_W-1:0]      retire_slot;
  logic                   retire_err;

  // Lookup and status
  logic [ADDR_WIDTH-1:0]  lookup_addr;
  logic                   lookup_hit;
  logic [SLOT_W-1:0]      lookup_slot;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   empty;

  modport master (
    output alloc_valid, alloc_addr, alloc_index, issue_ready, retire_valid, retire_slot,
           lookup_addr,
    input  alloc_ready, alloc_slot, issue_valid, issue_slot, issue_addr, issue_index,
           retire_err, lookup_hit, lookup_slot, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_index, issue_ready, retire_valid, retire_slot,
           lookup_addr,
    output alloc_ready, alloc_slot, issue_valid, issue_slot, issue_addr, issue_index,
           retire_err, lookup_hit, lookup_slot, count, full, empty
  );
endinterface

// File: rtl/nway_cache_tracker_table.sv
// Table of outstanding memory requests. Each slot walks free -> pending -> processing -> free.
// Pending slots issue oldest-first using an age matrix: older_q[i][j] = 1 means slot j was
// allocated before slot i.
module nway_cache_tracker_table #(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 17
) (
  input logic                      clk,
  input logic                      rst,
  nway_cache_tracker_table_if.slave bus
);
  localparam int unsigned SLOT_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);

  // Slot state
  logic [ENTRIES-1:0]     occupied_q, occupied_d;
  logic [ENTRIES-1:0]     processing_q, processing_d;
  logic [ENTRIES-1:0]     older_q [ENTRIES];
  logic [ENTRIES-1:0]     older_d [ENTRIES];
  logic [ADDR_WIDTH-1:0]  mem_addr_q [ENTRIES];
  logic [INDEX_WIDTH-1:0] trace_index_q [ENTRIES];
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   retire_err_q, retire_err_d;

  // Derived selections
  logic [ENTRIES-1:0] pending;
  logic               free_any;
  logic [SLOT_W-1:0]  alloc_slot;
  logic               issue_any;
  logic [SLOT_W-1:0]  issue_slot;
  logic               hit_any;
  logic [SLOT_W-1:0]  hit_slot;
  logic               alloc_ready;
  logic               issue_valid;
  logic               alloc_fire;
  logic               issue_fire;
  logic               retire_ok;

  // Lowest-numbered free slot; descending scan so the lowest index wins.
  always_comb begin
    free_any   = 1'b0;
    alloc_slot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occupied_q[i]) begin
        free_any   = 1'b1;
        alloc_slot = SLOT_W'(i);
      end
    end
  end

  // Oldest pending slot: pending with no older pending slot. At most one qualifies.
  always_comb begin
    pending    = occupied_q & ~processing_q;
    issue_any  = 1'b0;
    issue_slot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (pending[i] && ((older_q[i] & pending) == '0)) begin
        issue_any  = 1'b1;
        issue_slot = SLOT_W'(i);
      end
    end
  end

  // Address lookup over occupied slots, lowest match wins, 0 on miss.
  always_comb begin
    hit_any  = 1'b0;
    hit_slot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (occupied_q[i] && (mem_addr_q[i] == bus.lookup_addr)) begin
        hit_any  = 1'b1;
        hit_slot = SLOT_W'(i);
      end
    end
  end

  // Handshake qualification; nothing fires while reset is held.
  always_comb begin
    alloc_ready = !rst && free_any;
    issue_valid = !rst && issue_any;
    alloc_fire  = bus.alloc_valid && alloc_ready;
    issue_fire  = issue_valid && bus.issue_ready;
    retire_ok   = !rst && bus.retire_valid && occupied_q[bus.retire_slot] &&
                  processing_q[bus.retire_slot];
  end

  // Next-state: retire first, then issue and allocate (always distinct slots).
  always_comb begin
    occupied_d   = occupied_q;
    processing_d = processing_q;
    older_d      = older_q;
    count_d      = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_ok);
    // A retire on a free or still-pending slot is dropped and flagged next cycle.
    retire_err_d = !rst && bus.retire_valid && !retire_ok;

    if (retire_ok) begin
      occupied_d[bus.retire_slot]   = 1'b0;
      processing_d[bus.retire_slot] = 1'b0;
      older_d[bus.retire_slot]      = '0;
    end

    if (issue_fire) begin
      processing_d[issue_slot] = 1'b1;
    end

    if (alloc_fire) begin
      // Newcomer is younger than every slot still occupied and older than nobody.
      for (int i = 0; i < ENTRIES; i++) begin
        older_d[i][alloc_slot] = 1'b0;
      end
      older_d[alloc_slot]      = occupied_d;
      occupied_d[alloc_slot]   = 1'b1;
      processing_d[alloc_slot] = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied_q   <= '0;
      processing_q <= '0;
      count_q      <= '0;
      retire_err_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      occupied_q   <= occupied_d;
      processing_q <= processing_d;
      count_q      <= count_d;
      retire_err_q <= retire_err_d;
      for (int i = 0; i < ENTRIES; i++) begin
        older_q[i] <= older_d[i];
      end
    end
  end

  // Request payload, captured on allocation; only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_addr_q[alloc_slot]    <= bus.alloc_addr;
      trace_index_q[alloc_slot] <= bus.alloc_index;
    end
  end

  // Output drive, all from registered state.
  always_comb begin
    bus.alloc_ready = alloc_ready;
    bus.alloc_slot  = alloc_slot;
    bus.issue_valid = issue_valid;
    bus.issue_slot  = issue_slot;
    bus.issue_addr  = mem_addr_q[issue_slot];
    bus.issue_index = trace_index_q[issue_slot];
    bus.lookup_hit  = hit_any;
    bus.lookup_slot = hit_slot;
    bus.count       = count_q;
    bus.full        = (count_q == CNT_W'(ENTRIES));
    bus.empty       = (count_q == '0);
    bus.retire_err  = retire_err_q;
  end
endmodule

// File: tb/tb_nway_cache_tracker_table.sv
// Directed vector bench for nway_cache_tracker_table with ENTRIES=8.
module tb_nway_cache_tracker_table;
  localparam int unsigned ENTRIES     = 8;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH = 17;

  logic clk;
  logic rst;

  nway_cache_tracker_table_if #(
    .ENTRIES    (ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) bus ();

  nway_cache_tracker_table #(
    .ENTRIES    (ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] addr;
    int unsigned idx;
    logic        ir;
    logic        rv;
    int unsigned rs;
    logic [31:0] la;
    logic        e_ar;
    int unsigned e_as;
    logic        e_iv;
    int unsigned e_is;
    logic [31:0] e_ia;
    int unsigned e_ii;
    logic        e_lh;
    int unsigned e_ls;
    int unsigned e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst_v, input logic av, input logic [31:0] addr,
                   input int unsigned idx, input logic ir, input logic rv, input int unsigned rs,
                   input logic [31:0] la, input logic ar, input int unsigned as_e,
                   input logic iv, input int unsigned is_e, input logic [31:0] ia,
                   input int unsigned ii, input logic lh, input int unsigned ls,
                   input int unsigned cnt, input logic err);
    vec_t r;
    r.rst = rst_v;  r.av = av;     r.addr = addr;  r.idx = idx;    r.ir = ir;
    r.rv = rv;      r.rs = rs;     r.la = la;      r.e_ar = ar;    r.e_as = as_e;
    r.e_iv = iv;    r.e_is = is_e; r.e_ia = ia;    r.e_ii = ii;    r.e_lh = lh;
    r.e_ls = ls;    r.e_cnt = cnt; r.e_err = err;
    vecs.push_back(r);
  endtask

  task automatic idle_inputs();
    bus.alloc_valid  = 1'b0;
    bus.alloc_addr   = '0;
    bus.alloc_index  = '0;
    bus.issue_ready  = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_slot  = '0;
    bus.lookup_addr  = '0;
  endtask

  initial begin
    //  rst av addr   idx ir rv rs la      ar as iv is ia     ii  lh ls cnt err
    // Fill three, then all eight; extra alloc while full is ignored.
    v(0, 1, 'h100, 5,  0, 0, 0, 'h200,  1, 0, 0, 0, 'h0,   0,  0, 0, 0, 0);
    v(0, 1, 'h200, 6,  0, 0, 0, 'h200,  1, 1, 1, 0, 'h100, 5,  0, 0, 1, 0);
    v(0, 1, 'h300, 7,  0, 0, 0, 'h200,  1, 2, 1, 0, 'h100, 5,  1, 1, 2, 0);
    v(0, 1, 'h400, 8,  0, 0, 0, 'h200,  1, 3, 1, 0, 'h100, 5,  1, 1, 3, 0);
    v(0, 1, 'h500, 9,  0, 0, 0, 'h200,  1, 4, 1, 0, 'h100, 5,  1, 1, 4, 0);
    v(0, 1, 'h600, 10, 0, 0, 0, 'h200,  1, 5, 1, 0, 'h100, 5,  1, 1, 5, 0);
    v(0, 1, 'h700, 11, 0, 0, 0, 'h200,  1, 6, 1, 0, 'h100, 5,  1, 1, 6, 0);
    v(0, 1, 'h800, 12, 0, 0, 0, 'h200,  1, 7, 1, 0, 'h100, 5,  1, 1, 7, 0);
    v(0, 1, 'h900, 13, 1, 0, 0, 'h200,  0, 0, 1, 0, 'h100, 5,  1, 1, 8, 0);
    v(0, 1, 'h900, 13, 0, 1, 0, 'h200,  0, 0, 1, 1, 'h200, 6,  1, 1, 8, 0);
    // Reset with an alloc attempt: ignored, table cleared.
    v(1, 1, 'haaa, 1,  0, 0, 0, 'h200,  0, 0, 0, 0, 'h0,   0,  1, 1, 7, 0);
    // Age order: slots 0-3, retire 0, reallocate 0, issue sequence 1,2,3,0.
    v(0, 1, 'h100, 5,  0, 0, 0, 'h500,  1, 0, 0, 0, 'h0,   0,  0, 0, 0, 0);
    v(0, 1, 'h200, 6,  0, 0, 0, 'h500,  1, 1, 1, 0, 'h100, 5,  0, 0, 1, 0);
    v(0, 1, 'h300, 7,  0, 0, 0, 'h500,  1, 2, 1, 0, 'h100, 5,  0, 0, 2, 0);
    v(0, 1, 'h400, 8,  1, 0, 0, 'h500,  1, 3, 1, 0, 'h100, 5,  0, 0, 3, 0);
    v(0, 0, 'h0,   0,  0, 1, 0, 'h500,  1, 4, 1, 1, 'h200, 6,  0, 0, 4, 0);
    v(0, 1, 'h500, 9,  0, 0, 0, 'h500,  1, 0, 1, 1, 'h200, 6,  0, 0, 3, 0);
    v(0, 0, 'h0,   0,  1, 0, 0, 'h500,  1, 4, 1, 1, 'h200, 6,  1, 0, 4, 0);
    v(0, 0, 'h0,   0,  1, 0, 0, 'h500,  1, 4, 1, 2, 'h300, 7,  1, 0, 4, 0);
    v(0, 0, 'h0,   0,  1, 0, 0, 'h500,  1, 4, 1, 3, 'h400, 8,  1, 0, 4, 0);
    v(0, 0, 'h0,   0,  1, 0, 0, 'h500,  1, 4, 1, 0, 'h500, 9,  1, 0, 4, 0);
    // Illegal retire of free slot 4; then legal retire of slot 1 (lookup then misses).
    v(0, 0, 'h0,   0,  0, 1, 4, 'h200,  1, 4, 0, 0, 'h0,   0,  1, 1, 4, 0);
    v(0, 1, 'h600, 10, 0, 1, 1, 'h200,  1, 4, 0, 0, 'h0,   0,  1, 1, 4, 1);
    // Retire of pending slot 4, then retire together with its own issue.
    v(0, 0, 'h0,   0,  0, 1, 4, 'h200,  1, 1, 1, 4, 'h600, 10, 0, 0, 4, 0);
    v(0, 0, 'h0,   0,  1, 1, 4, 'h200,  1, 1, 1, 4, 'h600, 10, 0, 0, 4, 1);
    v(0, 0, 'h0,   0,  0, 0, 0, 'h200,  1, 1, 0, 0, 'h0,   0,  0, 0, 4, 1);
    // Five occupied, four processing, then reset mid-operation.
    v(0, 1, 'h700, 11, 0, 0, 0, 'h700,  1, 1, 0, 0, 'h0,   0,  0, 0, 4, 0);
    v(1, 0, 'h0,   0,  0, 0, 0, 'h700,  0, 0, 0, 0, 'h0,   0,  1, 1, 5, 0);
    v(0, 0, 'h0,   0,  0, 0, 0, 'h700,  1, 0, 0, 0, 'h0,   0,  0, 0, 0, 0);

    // Hand sequence: outputs held inactive while reset is asserted.
    rst = 1'b1;
    idle_inputs();
    bus.alloc_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_hold.alloc_ready", 32'(bus.alloc_ready), 32'd0);
    check("rst_hold.issue_valid", 32'(bus.issue_valid), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t r;
      r = vecs[k];
      @(negedge clk);
      rst              = r.rst;
      bus.alloc_valid  = r.av;
      bus.alloc_addr   = r.addr;
      bus.alloc_index  = INDEX_WIDTH'(r.idx);
      bus.issue_ready  = r.ir;
      bus.retire_valid = r.rv;
      bus.retire_slot  = 3'(r.rs);
      bus.lookup_addr  = r.la;
      #1;
      check($sformatf("v%0d.alloc_ready", k), 32'(bus.alloc_ready), 32'(r.e_ar));
      if (r.e_ar) check($sformatf("v%0d.alloc_slot", k), 32'(bus.alloc_slot), r.e_as);
      check($sformatf("v%0d.issue_valid", k), 32'(bus.issue_valid), 32'(r.e_iv));
      if (r.e_iv) begin
        check($sformatf("v%0d.issue_slot", k), 32'(bus.issue_slot), r.e_is);
        check($sformatf("v%0d.issue_addr", k), bus.issue_addr, r.e_ia);
        check($sformatf("v%0d.issue_index", k), 32'(bus.issue_index), r.e_ii);
      end
      check($sformatf("v%0d.lookup_hit", k), 32'(bus.lookup_hit), 32'(r.e_lh));
      check($sformatf("v%0d.lookup_slot", k), 32'(bus.lookup_slot), r.e_ls);
      check($sformatf("v%0d.count", k), 32'(bus.count), r.e_cnt);
      check($sformatf("v%0d.full", k), 32'(bus.full), 32'(r.e_cnt == ENTRIES));
      check($sformatf("v%0d.empty", k), 32'(bus.empty), 32'(r.e_cnt == 0));
      check($sformatf("v%0d.retire_err", k), 32'(bus.retire_err), 32'(r.e_err));
    end

    // Hand sequence: allocation becomes issuable exactly one cycle later.
    @(negedge clk);
    idle_inputs();
    rst             = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 32'hbeef;
    bus.alloc_index = 17'd3;
    #1;
    check("late.issue_valid_same_cycle", 32'(bus.issue_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("late.issue_valid", 32'(bus.issue_valid), 32'd1);
    check("late.issue_addr", bus.issue_addr, 32'hbeef);
    check("late.issue_index", 32'(bus.issue_index), 32'd3);
    check("late.count", 32'(bus.count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nway_cache_tracker_table.md
Name: nway_cache_tracker_table

Overview:
- Parametrised table of outstanding memory requests for the n-way trace repository. Generalises the single cache_tracker_t record to ENTRIES slots.
- Each slot follows the request lifecycle free -> pending (make request) -> processing (wait for processing) -> free (request retired).
- Adds oldest-first issue via an age matrix, address lookup, occupancy status and illegal-retire detection.
- Sits between trace capture, which allocates, and the cache request path, which issues and retires.

Parameters:
- ENTRIES, 8, number of tracker slots (>=2).
- ADDR_WIDTH, 32, memory address width (matches DATA_ADDR_WIDTH).
- INDEX_WIDTH, 17, trace index width (clog2 of TRACE_ENTRIES = 131072).
- SLOT_W and CNT_W are localparams: SLOT_W = clog2(ENTRIES), CNT_W = clog2(ENTRIES+1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  a free slot exists.
- alloc_addr  in  ADDR_WIDTH  request address.
- alloc_index  in  INDEX_WIDTH  trace index of the request.
- alloc_slot  out  SLOT_W  slot that will be used if the handshake fires.
- issue_valid  out  1  at least one pending slot exists.
- issue_ready  in  1  downstream accepts the issue.
- issue_slot  out  SLOT_W  oldest pending slot.
- issue_addr  out  ADDR_WIDTH  address of issue_slot.
- issue_index  out  INDEX_WIDTH  trace index of issue_slot.
- retire_valid  in  1  retire request.
- retire_slot  in  SLOT_W  slot to free.
- lookup_addr  in  ADDR_WIDTH  address query.
- lookup_hit  out  1  some occupied slot holds lookup_addr.
- lookup_slot  out  SLOT_W  lowest-numbered matching slot; 0 on miss.
- count  out  CNT_W  number of occupied slots.
- full  out  1  count == ENTRIES.
- empty  out  1  count == 0.
- retire_err  out  1  registered pulse flagging an illegal retire.

Behaviour:
- Per-slot state: occupied, processing, mem_addr, trace_index. Age matrix older[i][j] = 1 means slot j was allocated before slot i.
- Reset (synchronous): clear every occupied, processing and older bit. The cycle after reset: count=0, empty=1, full=0, issue_valid=0, lookup_hit=0, retire_err=0, alloc_ready=1. While rst is high, alloc_ready=0 and issue_valid=0, and all handshakes are ignored. Reset mid-operation discards all entries without retiring them.
- All outputs except retire_err are combinational from registered state. No same-cycle bypass of inputs.
- Allocate: fires when alloc_valid && alloc_ready.
  - alloc_slot is the lowest-numbered free slot.
  - The slot is set occupied=1, processing=0 with addr/index latched.
  - older[slot][j] <= occupied[j] for all j. Column older[*][slot] is cleared.
- Issue:
  - issue_slot is the unique pending slot (occupied && !processing) with no pending slot j where older[slot][j]=1.
  - On issue_valid && issue_ready, that slot's processing <= 1.
  - A slot allocated in cycle N is issuable from cycle N+1.
- Retire: retire_valid with the slot occupied && processing.
  - Clears occupied and processing and row older[slot][*].
  - The freed slot is allocatable from the next cycle, not the same cycle.
- Illegal retire: retire_valid on a slot that is free or not yet processing. State is unchanged and retire_err=1 in the following cycle only.
- Simultaneous events: alloc, issue and retire in one cycle all apply, and all target distinct slots by construction. Issue and retire of the same slot in one cycle cannot be legal, because processing is still 0, so it is flagged by retire_err.
- count is updated as +alloc -retire per cycle, range 0..ENTRIES. When full, alloc_valid is held with no effect.
- Latency: allocate-to-issue-visible is 1 cycle; retire-to-slot-reusable is 1 cycle.

Test Plan:
- Reset, then allocate (0x100,5), (0x200,6), (0x300,7) on consecutive cycles -> alloc_slot 0,1,2; count=3; issue_valid=1, issue_slot=0, issue_addr=0x100, issue_index=5.
- Allocate 8 entries with ENTRIES=8 -> full=1, alloc_ready=0; extra alloc_valid is ignored and count stays 8. Issue slot 0, retire slot 0 -> next cycle full=0, alloc_slot=0.
- Age order: allocate slots 0-3, issue and retire slot 0, allocate again (takes slot 0), hold issue_ready=1 -> issue_slot sequence 1,2,3,0.
- Lookup 0x200 with slot 1 occupied -> lookup_hit=1, lookup_slot=1. After slot 1 is retired -> lookup_hit=0, lookup_slot=0.
- Retire free slot 4, then retire pending-but-not-issued slot 2 -> retire_err=1 one cycle after each; count and state unchanged.
- With 5 slots occupied, 2 of them processing, assert rst for 1 cycle -> next cycle count=0, empty=1, issue_valid=0, alloc_slot=0.
